// File: rtl/cmp_arb_pkg.sv
// Shared types and the round-robin pick function for the comparator arbiter.
// The pick function is sized for up to MAX_REQ requesters; callers zero-extend.
package cmp_arb_pkg;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;
  localparam int J_W     = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit at or above ptr, wrapping at n-1 back to 0.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t         p;
    logic [J_W-1:0] j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = {1'b0, ptr} + J_W'(k);
      if (j >= J_W'(n)) j = j - J_W'(n);
      if (k < n && !p.found && valid[j[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/comparator.sv
// Combinational unsigned comparator; exactly one output is high for any a, b.
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             greater,
  output logic             lower
);

  assign equal   = (a == b);
  assign greater = (a > b);
  assign lower   = (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters.
// Each compare runs IDLE (grant) -> CMP (operands registered) -> RESP (result held).
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_equal,
  output logic                   rsp_greater,
  output logic                   rsp_lower,
  input  logic                   rsp_ready
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; req_ready is only raised in IDLE, rsp_valid holds until rsp_ready.

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;
  logic               grant_en;
  logic [ID_W-1:0]    grant_id;
  logic               cmp_equal, cmp_greater, cmp_lower;

  comparator #(.WIDTH(WIDTH)) u_comparator (
    .a       (op_a),
    .b       (op_b),
    .equal   (cmp_equal),
    .greater (cmp_greater),
    .lower   (cmp_lower)
  );

  always_comb begin
    valid_ext                = '0;
    valid_ext[N_REQ-1:0]     = req_valid;
    pick                     = rr_pick(valid_ext, IDX_W'(rr_ptr), N_REQ);
    grant_id                 = pick.idx[ID_W-1:0];
    state_d                  = state_q;
    req_ready                = '0;
    grant_en                 = 1'b0;
    case (state_q)
      IDLE: begin
        // The range guard keeps out-of-range codes from ever becoming a grant.
        if (!rst && pick.found && (32'(pick.idx) < N_REQ)) begin
          grant_en            = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_d             = CMP;
        end
      end
      CMP:     state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_equal   <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_lower   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        op_a <= req_a[int'(grant_id)*WIDTH +: WIDTH];
        op_b <= req_b[int'(grant_id)*WIDTH +: WIDTH];
        id_q <= grant_id;
      end
      if (state_q == CMP) begin
        rsp_valid   <= 1'b1;
        rsp_id      <= id_q;
        rsp_equal   <= cmp_equal;
        rsp_greater <= cmp_greater;
        rsp_lower   <= cmp_lower;
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid   <= 1'b0;
        rsp_equal   <= 1'b0;
        rsp_greater <= 1'b0;
        rsp_lower   <= 1'b0;
        rr_ptr      <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, table of single requests, round-robin,
// backpressure, pointer wrap and an exhaustive operand sweep.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_equal, rsp_greater, rsp_lower;
  logic        rsp_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] id;
    logic [3:0] a;
    logic [3:0] b;
    logic       eq;
    logic       gt;
    logic       lt;
  } vec_t;

  vec_t vecs[6];

  cmp_arbiter #(.WIDTH(4), .N_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_equal   (rsp_equal),
    .rsp_greater (rsp_greater),
    .rsp_lower   (rsp_lower),
    .rsp_ready   (rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id,
                           input logic eq, input logic gt, input logic lt);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, " flags"}, {29'd0, rsp_equal, rsp_greater, rsp_lower}, {29'd0, eq, gt, lt});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, " flags"}, {29'd0, rsp_equal, rsp_greater, rsp_lower}, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called one tick after a rising edge with the DUT in IDLE; returns the same way.
  task automatic apply_single(input string tag, input logic [1:0] id,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic eq, input logic gt, input logic lt);
    rsp_ready = 1'b1;
    req_valid = 4'b0001 << id;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_a[int'(id)*4 +: 4] = a;
    req_b[int'(id)*4 +: 4] = b;
    @(negedge clk);
    check({tag, " grant"}, 32'(req_ready), 32'(4'b0001 << id));
    next_cycle();
    req_valid = '0;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    @(negedge clk);
    check({tag, " cmp rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " cmp req_ready"}, 32'(req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check_rsp(tag, id, eq, gt, lt);
    next_cycle();
    @(negedge clk);
    check({tag, " after accept"}, {28'd0, rsp_valid, rsp_equal, rsp_greater, rsp_lower}, 32'd0);
    next_cycle();
  endtask

  logic [2:0] rr_exp[5];

  initial begin
    vecs[0] = '{id: 2'd2, a: 4'd7,  b: 4'd7,  eq: 1'b1, gt: 1'b0, lt: 1'b0};
    vecs[1] = '{id: 2'd0, a: 4'd0,  b: 4'd0,  eq: 1'b1, gt: 1'b0, lt: 1'b0};
    vecs[2] = '{id: 2'd1, a: 4'd15, b: 4'd14, eq: 1'b0, gt: 1'b1, lt: 1'b0};
    vecs[3] = '{id: 2'd3, a: 4'd0,  b: 4'd15, eq: 1'b0, gt: 1'b0, lt: 1'b1};
    vecs[4] = '{id: 2'd1, a: 4'd8,  b: 4'd7,  eq: 1'b0, gt: 1'b1, lt: 1'b0};
    vecs[5] = '{id: 2'd2, a: 4'd1,  b: 4'd2,  eq: 1'b0, gt: 1'b0, lt: 1'b1};
    // {eq, gt, lt} for requester i comparing a=i against b=2, grants 0,1,2,3,0
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b010; rr_exp[4] = 3'b001;

    // Reset with every requester pending: nothing may be granted.
    req_valid = 4'b1111;
    #7;
    check_all_zero("reset");
    req_valid = '0;
    next_cycle();
    rst = 1'b0;

    // Reset during CMP drops the request.
    req_valid = 4'b0001;
    req_a     = 16'h0005;
    req_b     = 16'h0009;
    @(negedge clk);
    check("rst_cmp grant", 32'(req_ready), 32'd1);
    next_cycle();
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check_all_zero("rst_cmp");
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_cmp no rsp", 32'(rsp_valid), 32'd0);
      next_cycle();
    end

    // All four pending: grants start at 0 (pointer was reset) and rotate.
    rsp_ready = 1'b1;
    req_a     = 16'h3210;
    req_b     = 16'h2222;
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      case (c % 3)
        0: check("rr grant", 32'(req_ready), 32'(4'b0001 << ((c / 3) % 4)));
        1: check("rr spacing", {30'd0, rsp_valid, |req_ready}, 32'd0);
        default: check_rsp("rr", 2'((c / 3) % 4), rr_exp[c / 3][2], rr_exp[c / 3][1], rr_exp[c / 3][0]);
      endcase
      next_cycle();
    end
    req_valid = '0;

    for (int i = 0; i < 6; i++)
      apply_single("table", vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].gt, vecs[i].lt);

    // Backpressure: result held while rsp_ready is low, others kept waiting.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_a     = 16'h000F;
    req_b     = 16'h0000;
    @(negedge clk);
    check("bp grant", 32'(req_ready), 32'd1);
    next_cycle();
    req_valid = 4'b1110;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    check("bp cmp", {30'd0, rsp_valid, |req_ready}, 32'd0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_rsp("bp hold", 2'd0, 1'b0, 1'b1, 1'b0);
      check("bp req_ready", 32'(req_ready), 32'd0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_rsp("bp accept", 2'd0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    check("bp released", 32'(rsp_valid), 32'd0);
    check("bp next grant", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_rsp("bp drain", 2'd1, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Serve id 3 so the pointer wraps to 0, then 4'b1010 grants 1 then 3.
    apply_single("wrap pre", 2'd3, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0);
    req_a     = 16'h2090;
    req_b     = 16'h6030;
    req_valid = 4'b1010;
    @(negedge clk);
    check("wrap grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_rsp("wrap rsp1", 2'd1, 1'b0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    check("wrap grant3", 32'(req_ready), 32'b1000);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check_rsp("wrap rsp3", 2'd3, 1'b0, 1'b0, 1'b1);
    next_cycle();

    // Exhaustive operand sweep against a reference compare.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        apply_single("sweep", 2'd1, 4'(a), 4'(b), a == b, a > b, a < b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one instance of the team's combinational `comparator` (WIDTH-bit unsigned; equal/greater/lower) between N_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request side and the response side.
- Sequences each compare through a 3-state FSM: registered operands, then a registered result held until the consumer accepts it.
- Sits between multiple client blocks and the single comparator datapath.

Parameters:
- WIDTH, 4: operand width in bits; unsigned compare.
- N_REQ, 4: number of requesters; must be >= 2.
- ID_W, $clog2(N_REQ): width of the requester index; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i has an operand pair pending.
- req_a  input  N_REQ*WIDTH  operand a for requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand b for requester i, same packing as req_a.
- req_ready  output  N_REQ  one-hot or zero; bit i high means requester i's operands are captured this cycle.
- rsp_valid  output  1  result available.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_equal  output  1  a == b for the owning request.
- rsp_greater  output  1  a > b for the owning request.
- rsp_lower  output  1  a < b for the owning request.
- rsp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async assert, any state), all outputs 0:
  - state = IDLE, rr_ptr = 0.
  - Operand registers = 0.
  - rsp_valid, rsp_id, rsp_equal, rsp_greater, rsp_lower = 0.
  - req_ready = 0.
  - An in-flight request is dropped; no response is issued for it.
- FSM IDLE:
  - If any req_valid is set, grant g = first set bit searching from rr_ptr upward, wrapping at N_REQ-1 to 0.
  - req_ready[g] = 1 combinationally, this cycle only.
  - At the clock edge: capture req_a[g], req_b[g] and g into op_a, op_b, id_q, then go to CMP.
  - If no req_valid is set: stay in IDLE; req_ready = 0.
- FSM CMP:
  - The comparator sub-module sees op_a and op_b.
  - At the clock edge: register equal/greater/lower into rsp_* and id_q into rsp_id, set rsp_valid = 1, go to RESP.
  - req_ready = 0.
- FSM RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready at the edge:
    - rsp_valid and all three flags go to 0 (rsp_id may hold its value).
    - rr_ptr = (id_q + 1) mod N_REQ.
    - Go to IDLE.
  - req_ready = 0 throughout.
- Latency and throughput:
  - Grant at cycle T; rsp_valid = 1 at cycle T+2.
  - With rsp_ready tied high, one compare completes every 3 cycles.
- Result invariant:
  - When rsp_valid = 1, exactly one of equal/greater/lower is 1.
  - When rsp_valid = 0, all three flags are 0.
- Requester rules:
  - A requester may drop req_valid before it is granted; no state is affected.
  - Operands only need to be valid in the grant cycle.
  - Only requesters not currently granted are ignored; no request is queued beyond req_valid itself.
- Fairness and wrap:
  - rr_ptr advances only when a response is accepted.
  - With all N_REQ requesters valid continuously, grants cycle 0,1,...,N_REQ-1,0,...
  - rr_ptr wraps from N_REQ-1 to 0.
- Simultaneous events:
  - The response handshake and new requests arriving in RESP do not overlap. The new grant happens in the following IDLE cycle, using the updated rr_ptr.
- Width rules:
  - Compare is unsigned across the full WIDTH; no sign extension.
  - rsp_id is zero-extended as needed when N_REQ is not a power of 2.
  - Grant search is modulo N_REQ; ID_W codes >= N_REQ are never produced.

Decomposition:
- Package cmp_arb_pkg:
  - state enum {IDLE, CMP, RESP} (2-bit encoding).
  - Function rr_pick(req_valid, rr_ptr), returning grant index plus a found flag.
- Sub-module: instantiate the existing `comparator` module as-is, with .WIDTH(WIDTH), fed from op_a and op_b.
- The arbiter pick logic stays inline in cmp_arbiter; no separate module.

Test Plan:
- Reset mid-CMP:
  - Stimulus: req_valid=4'b0001, a=5, b=9; assert rst during the CMP cycle.
  - Required: all outputs 0 immediately; after release, rsp_valid never rises for that request; rr_ptr = 0.
- Single request:
  - Stimulus: req_valid[2]=1, a=7, b=7, rsp_ready=1.
  - Required: req_ready=4'b0100 in cycle T; at T+2 rsp_valid=1, rsp_id=2, equal=1, greater=0, lower=0; at T+3 rsp_valid=0.
- Round-robin with all requesters valid:
  - Stimulus: req_valid=4'b1111, rsp_ready=1; requester i drives a=i, b=2.
  - Required: grant order 0,1,2,3,0; results lower, lower, equal, greater, lower; 3-cycle spacing between responses.
- Backpressure:
  - Stimulus: single request a=15, b=0, with rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_valid, rsp_greater=1 and rsp_id stable for all 5 cycles; req_ready=0 even though other req_valid bits are set; release happens on the accept edge.
- Pointer skip and wrap:
  - Stimulus: serve id 3, then req_valid=4'b1010.
  - Required: next grant is 1 (search wraps 0 → 1); then, with 4'b1010 still asserted, the following grant is 3.
- Exhaustive sweep:
  - Stimulus: a single requester sweeps all 16x16 (a,b) pairs at WIDTH=4.
  - Required: each response matches the reference model, with exactly one flag set per response.
